// File: rtl/tilelink_ul_mem_slave.sv
`timescale 1ns/1ps
// TL-UL slave endpoint serving a word-addressed register-file memory.
// One outstanding transaction at a time: IDLE -> ACCESS -> RESP.
module tilelink_ul_mem_slave #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int                    SIZE_WIDTH   = 3,
    parameter int                    OPCODE_WIDTH = 3,
    parameter int                    PARAM_WIDTH  = 3,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000,
    parameter int                    MEM_DEPTH    = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [OPCODE_WIDTH-1:0] a_opcode,
    input  logic [PARAM_WIDTH-1:0]  a_param,
    input  logic [SIZE_WIDTH-1:0]   a_size,
    input  logic                    a_source,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [MASK_WIDTH-1:0]   a_mask,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [OPCODE_WIDTH-1:0] d_opcode,
    output logic [PARAM_WIDTH-1:0]  d_param,
    output logic [SIZE_WIDTH-1:0]   d_size,
    output logic                    d_source,
    output logic                    d_sink,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_error
);
    localparam int                      IDX_WIDTH          = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]     SPAN_BYTES         = (ADDR_WIDTH+1)'(4 * MEM_DEPTH);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL        = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PARTIAL     = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_GET             = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACCESS_ACK      = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACCESS_ACK_DATA = OPCODE_WIDTH'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    state_t                  state, state_next;
    logic [OPCODE_WIDTH-1:0] req_opcode;
    logic [SIZE_WIDTH-1:0]   req_size;
    logic                    req_source;
    logic [ADDR_WIDTH-1:0]   req_address;
    logic [MASK_WIDTH-1:0]   req_mask;
    logic [DATA_WIDTH-1:0]   req_data;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [ADDR_WIDTH:0]     addr_diff;
    logic [IDX_WIDTH-1:0]    word_idx;
    logic                    out_of_range, bad_size, is_get, is_put, req_error;
    logic                    mem_we, a_fire, d_fire;
    logic                    unused_param;

    assign unused_param = ^a_param;
    assign a_fire       = a_valid && a_ready;
    assign d_fire       = d_valid && d_ready;
    assign d_param      = '0;
    assign d_sink       = 1'b0;

    // Addresses below BASE_ADDR borrow into the top bit, so one compare covers both bounds.
    assign addr_diff    = {1'b0, req_address} - {1'b0, BASE_ADDR};
    assign out_of_range = addr_diff >= SPAN_BYTES;
    assign word_idx     = addr_diff[IDX_WIDTH+1:2];
    assign is_get       = (req_opcode == OP_GET);
    assign is_put       = (req_opcode == OP_PUT_FULL) || (req_opcode == OP_PUT_PARTIAL);
    assign req_error    = out_of_range || bad_size || !(is_get || is_put);
    assign mem_we       = (state == ST_ACCESS) && is_put && !req_error;

    always_comb begin
        case (req_size)
            SIZE_WIDTH'(0): bad_size = 1'b0;
            SIZE_WIDTH'(1): bad_size = req_address[0];
            SIZE_WIDTH'(2): bad_size = |req_address[1:0];
            default:        bad_size = 1'b1;
        endcase
    end

    always_comb begin
        // NOTE: assign the default before the case so no path can infer a latch.
        state_next = state;
        case (state)
            ST_IDLE:   if (a_fire) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   if (d_fire) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            a_ready     <= 1'b0;
            req_opcode  <= '0;
            req_size    <= '0;
            req_source  <= 1'b0;
            req_address <= '0;
            req_mask    <= '0;
            req_data    <= '0;
            d_valid     <= 1'b0;
            d_opcode    <= '0;
            d_size      <= '0;
            d_source    <= 1'b0;
            d_data      <= '0;
            d_error     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            state   <= state_next;
            a_ready <= (state_next == ST_IDLE);
            if (a_fire) begin
                req_opcode  <= a_opcode;
                req_size    <= a_size;
                req_source  <= a_source;
                req_address <= a_address;
                req_mask    <= a_mask;
                req_data    <= a_data;
            end
            if (state == ST_ACCESS) begin
                d_valid  <= 1'b1;
                d_opcode <= is_get ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK;
                d_size   <= req_size;
                d_source <= req_source;
                d_error  <= req_error;
                d_data   <= (is_get && !req_error) ? mem[word_idx] : '0;
            end else if (d_fire) begin
                d_valid <= 1'b0;
            end
        end
    end

    // NOTE: the storage array has no reset; contents stay undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (req_mask[i]) mem[word_idx][8*i +: 8] <= req_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_tilelink_ul_mem_slave.sv
`timescale 1ns/1ps
// Self-checking bench for tilelink_ul_mem_slave: directed scenarios plus
// randomized traffic checked against a byte-level memory model.
module tb_tilelink_ul_mem_slave;
    localparam longint BASE  = 0;
    localparam longint DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_valid, a_ready;
    logic [2:0]  a_opcode, a_param, a_size;
    logic        a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid, d_ready;
    logic [2:0]  d_opcode, d_param, d_size;
    logic        d_source, d_sink;
    logic [31:0] d_data;
    logic        d_error;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem   [256];
    logic [3:0]  model_known [256];

    tilelink_ul_mem_slave dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
        .d_error(d_error)
    );

    always #21 clk = ~clk;

    function automatic bit exp_error(logic [2:0] op, logic [2:0] size, logic [31:0] addr);
        longint a = longint'(addr);
        if (a < BASE || a >= BASE + 4 * DEPTH) return 1'b1;
        if (size > 3'd2) return 1'b1;
        if (a % (longint'(1) << size) != 0) return 1'b1;
        if (!(op inside {3'd0, 3'd1, 3'd4})) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int word_of(logic [31:0] addr);
        return int'((longint'(addr) - BASE) / 4);
    endfunction

    function automatic void model_write(logic [31:0] addr, logic [3:0] mask, logic [31:0] data);
        int idx = word_of(addr);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                model_mem[idx][8*i +: 8] = data[8*i +: 8];
                model_known[idx][i] = 1'b1;
            end
        end
    endfunction

    // Issues one request, checks accept/latency, returns the D beat; completes it if d_ready=1.
    task automatic do_txn(input logic [2:0] op, input logic [2:0] size, input logic src,
                          input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                          output logic [2:0] r_op, output logic [2:0] r_size, output logic r_src,
                          output logic [31:0] r_data, output logic r_err);
        int n;
        a_valid = 1'b1; a_opcode = op; a_param = 3'($urandom); a_size = size;
        a_source = src; a_address = addr; a_mask = mask; a_data = data;
        n = 0;
        while (!a_ready && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: a_ready=%b required 1", a_ready);
            a_valid = 1'b0;
            r_op = 'x; r_size = 'x; r_src = 'x; r_data = 'x; r_err = 'x;
            return;
        end
        @(posedge clk); #1;
        // Scramble channel A after acceptance; the slave must only use accept-edge values.
        a_valid = 1'($urandom); a_opcode = 3'($urandom); a_size = 3'($urandom);
        a_source = 1'($urandom); a_address = $urandom; a_mask = 4'($urandom); a_data = $urandom;
        checks++;
        if (a_ready !== 1'b0) begin
            errors++;
            $display("FAIL a_ready_after_accept: got %b required 0", a_ready);
        end
        n = 1;
        while (d_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != 2 || d_valid !== 1'b1) begin
            errors++;
            $display("FAIL d_valid_latency: got %0d cycles (d_valid=%b) required 2", n, d_valid);
        end
        r_op = d_opcode; r_size = d_size; r_src = d_source; r_data = d_data; r_err = d_error;
        if (d_ready) begin @(posedge clk); #1; end
        a_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; a_valid = 1'b0; d_ready = 1'b1;
        a_opcode = '0; a_param = '0; a_size = '0; a_source = 1'b0;
        a_address = '0; a_mask = '0; a_data = '0;
        #100;
        checks++;
        if (a_ready !== 1'b0) begin
            errors++; $display("FAIL reset_a_ready: got %b required 0", a_ready);
        end
        checks++;
        if ({d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error} !== '0) begin
            errors++;
            $display("FAIL reset_d_outputs: valid=%b op=%0d data=%h err=%b required all 0",
                     d_valid, d_opcode, d_data, d_error);
        end
        @(posedge clk); #5; reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_a_ready: got %b required 1", a_ready);
        end
    endtask

    task automatic test_write_read;
        logic [2:0] r_op, r_size; logic r_src, r_err; logic [31:0] r_data;
        do_txn(3'd0, 3'd2, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, r_op, r_size, r_src, r_data, r_err);
        model_write(32'h10, 4'hF, 32'hDEADBEEF);
        checks++;
        if (r_op !== 3'd0 || r_err !== 1'b0 || r_src !== 1'b1 || r_size !== 3'd2) begin
            errors++;
            $display("FAIL putfull_ack: op=%0d err=%b src=%b size=%0d required op=0 err=0 src=1 size=2",
                     r_op, r_err, r_src, r_size);
        end
        checks++;
        if (d_param !== 3'd0 || d_sink !== 1'b0) begin
            errors++; $display("FAIL d_param_sink: param=%0d sink=%b required 0 0", d_param, d_sink);
        end
        do_txn(3'd4, 3'd2, 1'b0, 32'h10, 4'hF, 32'h0, r_op, r_size, r_src, r_data, r_err);
        checks++;
        if (r_op !== 3'd1 || r_err !== 1'b0 || r_src !== 1'b0 || r_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL get_after_put: op=%0d err=%b src=%b data=%h required op=1 err=0 src=0 data=deadbeef",
                     r_op, r_err, r_src, r_data);
        end
    endtask

    task automatic test_partial_write;
        logic [2:0] r_op, r_size; logic r_src, r_err; logic [31:0] r_data;
        do_txn(3'd1, 3'd2, 1'b0, 32'h10, 4'h4, 32'h00AA0000, r_op, r_size, r_src, r_data, r_err);
        model_write(32'h10, 4'h4, 32'h00AA0000);
        checks++;
        if (r_op !== 3'd0 || r_err !== 1'b0) begin
            errors++; $display("FAIL putpartial_ack: op=%0d err=%b required op=0 err=0", r_op, r_err);
        end
        do_txn(3'd4, 3'd2, 1'b1, 32'h10, 4'hF, 32'h0, r_op, r_size, r_src, r_data, r_err);
        checks++;
        if (r_data !== 32'hDEAABEEF || r_err !== 1'b0) begin
            errors++; $display("FAIL partial_readback: data=%h err=%b required deaabeef 0", r_data, r_err);
        end
    endtask

    task automatic test_errors;
        logic [2:0] r_op, r_size; logic r_src, r_err; logic [31:0] r_data;
        logic [2:0]  ops   [5] = '{3'd4, 3'd4, 3'd2, 3'd4, 3'd0};
        logic [2:0]  sizes [5] = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd2};
        logic [31:0] addrs [5] = '{32'h400, 32'h11, 32'h10, 32'h10, 32'h400};
        do_txn(3'd0, 3'd2, 1'b0, 32'h0, 4'hF, 32'hCAFEF00D, r_op, r_size, r_src, r_data, r_err);
        model_write(32'h0, 4'hF, 32'hCAFEF00D);
        for (int i = 0; i < 5; i++) begin
            do_txn(ops[i], sizes[i], 1'b1, addrs[i], 4'hF, 32'h12345678, r_op, r_size, r_src, r_data, r_err);
            checks++;
            if (r_err !== 1'b1 || r_data !== 32'h0 || r_op !== ((ops[i] == 3'd4) ? 3'd1 : 3'd0)) begin
                errors++;
                $display("FAIL error_case_%0d: err=%b data=%h op=%0d required err=1 data=0 op=%0d",
                         i, r_err, r_data, r_op, (ops[i] == 3'd4) ? 1 : 0);
            end
        end
        do_txn(3'd4, 3'd2, 1'b0, 32'h10, 4'hF, 32'h0, r_op, r_size, r_src, r_data, r_err);
        checks++;
        if (r_data !== 32'hDEAABEEF) begin
            errors++; $display("FAIL word_10_unchanged: got %h required deaabeef", r_data);
        end
        do_txn(3'd4, 3'd2, 1'b0, 32'h0, 4'hF, 32'h0, r_op, r_size, r_src, r_data, r_err);
        checks++;
        if (r_data !== 32'hCAFEF00D) begin
            errors++; $display("FAIL word_0_unchanged: got %h required cafef00d", r_data);
        end
        do_txn(3'd0, 3'd2, 1'b0, 32'h3FC, 4'hF, 32'h5A5A1234, r_op, r_size, r_src, r_data, r_err);
        model_write(32'h3FC, 4'hF, 32'h5A5A1234);
        do_txn(3'd4, 3'd2, 1'b1, 32'h3FC, 4'hF, 32'h0, r_op, r_size, r_src, r_data, r_err);
        checks++;
        if (r_err !== 1'b0 || r_data !== 32'h5A5A1234) begin
            errors++; $display("FAIL last_word: err=%b data=%h required 0 5a5a1234", r_err, r_data);
        end
    endtask

    task automatic test_backpressure;
        logic [2:0] r_op, r_size; logic r_src, r_err; logic [31:0] r_data;
        logic [40:0] snap;
        d_ready = 1'b0;
        do_txn(3'd4, 3'd2, 1'b1, 32'h10, 4'hF, 32'h0, r_op, r_size, r_src, r_data, r_err);
        snap = {d_opcode, d_size, d_source, d_data, d_error};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (d_valid !== 1'b1 || a_ready !== 1'b0 || {d_opcode, d_size, d_source, d_data, d_error} !== snap) begin
                errors++;
                $display("FAIL stall_cycle_%0d: d_valid=%b a_ready=%b d=%h required 1 0 %h", i, d_valid,
                         a_ready, {d_opcode, d_size, d_source, d_data, d_error}, snap);
            end
        end
        checks++;
        if (r_data !== 32'hDEAABEEF || r_src !== 1'b1) begin
            errors++; $display("FAIL stall_data: data=%h src=%b required deaabeef 1", r_data, r_src);
        end
        d_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (d_valid !== 1'b0 || a_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release: d_valid=%b a_ready=%b required 0 1", d_valid, a_ready);
        end
    endtask

    task automatic test_reset_mid;
        logic [2:0] r_op, r_size; logic r_src, r_err; logic [31:0] r_data;
        d_ready = 1'b0;
        do_txn(3'd4, 3'd2, 1'b1, 32'h10, 4'hF, 32'h0, r_op, r_size, r_src, r_data, r_err);
        #5 reset_n = 1'b0;
        #1;
        checks++;
        if (d_valid !== 1'b0 || a_ready !== 1'b0 || d_data !== 32'h0 || d_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: d_valid=%b a_ready=%b d_data=%h required 0 0 0",
                     d_valid, a_ready, d_data);
        end
        @(posedge clk); #5; reset_n = 1'b1; d_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_idle: a_ready=%b d_valid=%b required 1 0", a_ready, d_valid);
        end
        do_txn(3'd4, 3'd2, 1'b0, 32'h10, 4'hF, 32'h0, r_op, r_size, r_src, r_data, r_err);
        checks++;
        if (r_data !== 32'hDEAABEEF || r_err !== 1'b0) begin
            errors++; $display("FAIL reset_mid_resume: data=%h err=%b required deaabeef 0", r_data, r_err);
        end
    endtask

    task automatic test_throughput;
        int          acc_cyc[$];
        logic        exp_src[$];
        logic [31:0] exp_addr[$];
        int          cyc, n_resp;
        bit          acc_now, rsp_now;
        logic        rsp_src;
        logic [31:0] rsp_data;
        d_ready = 1'b1;
        cyc = 0;
        while (!a_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
        a_valid = 1'b1; a_opcode = 3'd4; a_size = 3'd2; a_mask = 4'hF;
        a_source = 1'($urandom); a_address = 32'h10;
        exp_src.push_back(a_source); exp_addr.push_back(a_address);
        cyc = 0; n_resp = 0;
        while (n_resp < 4 && cyc < 60) begin
            acc_now = a_valid && a_ready;
            rsp_now = d_valid && d_ready;
            rsp_src = d_source; rsp_data = d_data;
            @(posedge clk); #1; cyc++;
            if (acc_now) begin
                acc_cyc.push_back(cyc);
                if (acc_cyc.size() < 4) begin
                    a_source  = 1'($urandom);
                    a_address = (acc_cyc.size() % 2 == 1) ? 32'h0 : 32'h10;
                    exp_src.push_back(a_source); exp_addr.push_back(a_address);
                end else begin
                    a_valid = 1'b0;
                end
            end
            if (rsp_now) begin
                checks++;
                if (rsp_src !== exp_src[n_resp] || rsp_data !== model_mem[word_of(exp_addr[n_resp])]) begin
                    errors++;
                    $display("FAIL throughput_resp_%0d: src=%b data=%h required %b %h", n_resp, rsp_src,
                             rsp_data, exp_src[n_resp], model_mem[word_of(exp_addr[n_resp])]);
                end
                n_resp++;
            end
        end
        a_valid = 1'b0;
        checks++;
        if (n_resp != 4 || acc_cyc.size() != 4) begin
            errors++;
            $display("FAIL throughput_count: responses=%0d accepts=%0d required 4 4", n_resp, acc_cyc.size());
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
                errors++;
                $display("FAIL accept_spacing_%0d: got %0d cycles required 3", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
    endtask

    task automatic test_random;
        logic [2:0] r_op, r_size; logic r_src, r_err; logic [31:0] r_data;
        logic [2:0] op, size; logic src; logic [31:0] addr, data, exp_data; logic [3:0] mask;
        bit err;
        int sel, idx;
        for (int w = 0; w < 16; w++) begin
            data = $urandom;
            do_txn(3'd0, 3'd2, 1'b0, 32'(w * 4), 4'hF, data, r_op, r_size, r_src, r_data, r_err);
            model_write(32'(w * 4), 4'hF, data);
        end
        for (int t = 0; t < 40; t++) begin
            sel  = $urandom_range(0, 9);
            op   = (sel < 4) ? 3'd4 : (sel < 6) ? 3'd0 : (sel < 8) ? 3'd1 : 3'($urandom_range(5, 7));
            if (sel == 9 && $urandom_range(0, 1) == 0) op = 3'($urandom_range(2, 3));
            size = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && size <= 3'd2) addr = addr & ~((32'd1 << size) - 32'd1);
            if ($urandom_range(0, 9) == 0) addr = 32'h400 + 32'($urandom_range(0, 4095));
            src  = 1'($urandom);
            mask = 4'($urandom);
            data = $urandom;
            err  = exp_error(op, size, addr);
            do_txn(op, size, src, addr, mask, data, r_op, r_size, r_src, r_data, r_err);
            checks++;
            if (r_err !== err || r_op !== ((op == 3'd4) ? 3'd1 : 3'd0) || r_src !== src || r_size !== size) begin
                errors++;
                $display("FAIL rand_%0d_hdr: err=%b op=%0d src=%b size=%0d required %b %0d %b %0d (req op=%0d addr=%h)",
                         t, r_err, r_op, r_src, r_size, err, (op == 3'd4) ? 1 : 0, src, size, op, addr);
            end
            if (err || op == 3'd4) begin
                idx = err ? 0 : word_of(addr);
                exp_data = err ? 32'h0 : model_mem[idx];
                if (err || model_known[idx] == 4'hF) begin
                    checks++;
                    if (r_data !== exp_data) begin
                        errors++;
                        $display("FAIL rand_%0d_data: got %h required %h (addr=%h)", t, r_data, exp_data, addr);
                    end
                end
            end else begin
                model_write(addr, mask, data);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin model_mem[i] = '0; model_known[i] = '0; end
        test_reset();
        test_write_read();
        test_partial_write();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_throughput();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
